// File: rtl/trdb_pkg.sv
// Shared types for the trace decoder branch-map path.
// Slot storage layout, slot-level state encoding and the per-slot update helper.
package trdb_pkg;

  localparam int BRANCH_MAP_LEN = 31;
  localparam int BRANCH_CNT_W   = 5;

  localparam logic [BRANCH_CNT_W:0] CNT_ONE = (BRANCH_CNT_W+1)'(1);

  typedef struct packed {
    logic [BRANCH_MAP_LEN-1:0] bits;
    logic [BRANCH_CNT_W:0]     cnt;
    logic                      valid;
  } branch_map_slot_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } bmap_state_e;

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_CLEAR,
    SLOT_LOAD,
    SLOT_SHIFT
  } slot_op_e;

  // Shifting out the final branch leaves the slot empty with a zero count,
  // so remaining can simply add both counts.
  function automatic branch_map_slot_t slot_update(input branch_map_slot_t cur,
                                                   input slot_op_e         op,
                                                   input branch_map_slot_t src);
    branch_map_slot_t nxt;
    nxt = cur;
    case (op)
      SLOT_CLEAR: nxt = '0;
      SLOT_LOAD:  nxt = src;
      SLOT_SHIFT: begin
        nxt.bits  = cur.bits >> 1;
        nxt.cnt   = cur.cnt - CNT_ONE;
        nxt.valid = (cur.cnt != CNT_ONE);
      end
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/trdb_branch_map_decoder.sv
// Replays double-buffered branch maps as one taken/not-taken outcome per cycle.
// 1-cycle accept-to-output latency; map_ready drops only while both slots are full.
module trdb_branch_map_decoder
  import trdb_pkg::*;
#(
  parameter int MAP_LEN = BRANCH_MAP_LEN,
  parameter int CNT_W   = BRANCH_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               map_valid_i,
  output logic               map_ready_o,
  input  logic [CNT_W-1:0]   map_count_i,
  input  logic [MAP_LEN-1:0] map_bits_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_taken_o,
  output logic               out_last_o,
  output logic [CNT_W:0]     remaining_o
);

  localparam logic [CNT_W:0] FULL_CNT = (CNT_W+1)'(MAP_LEN);

  bmap_state_e      state, state_nxt;
  branch_map_slot_t act, pend;
  branch_map_slot_t in_slot, act_src;
  slot_op_e         act_op, pend_op;
  logic             accept, fire, last_fire;

  assign fire      = act.valid && out_ready_i;
  assign last_fire = fire && (act.cnt == CNT_ONE);
  assign accept    = map_valid_i && map_ready_o;

  always_comb begin
    in_slot       = '0;
    in_slot.bits  = map_bits_i;
    in_slot.cnt   = (map_count_i == '0) ? FULL_CNT : {1'b0, map_count_i};
    in_slot.valid = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    act_op    = SLOT_HOLD;
    pend_op   = SLOT_HOLD;
    act_src   = in_slot;
    if (flush_i) begin
      state_nxt = EMPTY;
      act_op    = SLOT_CLEAR;
      pend_op   = SLOT_CLEAR;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            act_op    = SLOT_LOAD;
            state_nxt = ONE;
          end
        end
        ONE: begin
          // A map arriving as the last branch drains goes straight to ACTIVE.
          if (accept && last_fire) begin
            act_op = SLOT_LOAD;
          end else if (accept) begin
            pend_op   = SLOT_LOAD;
            act_op    = fire ? SLOT_SHIFT : SLOT_HOLD;
            state_nxt = TWO;
          end else if (fire) begin
            act_op    = SLOT_SHIFT;
            state_nxt = last_fire ? EMPTY : ONE;
          end
        end
        TWO: begin
          if (last_fire) begin
            act_src   = pend;
            act_op    = SLOT_LOAD;
            pend_op   = SLOT_CLEAR;
            state_nxt = ONE;
          end else if (fire) begin
            act_op = SLOT_SHIFT;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act  <= '0;
      pend <= '0;
    end else begin
      act  <= slot_update(act, act_op, act_src);
      pend <= slot_update(pend, pend_op, in_slot);
    end
  end

  always_comb begin
    map_ready_o = (state != TWO) && !flush_i;
    out_valid_o = act.valid;
    out_taken_o = act.valid && !act.bits[0];
    out_last_o  = act.valid && (act.cnt == CNT_ONE);
    remaining_o = act.cnt + pend.cnt;
  end

endmodule

// File: tb/tb_trdb_branch_map_decoder.sv
// Directed scenarios followed by random traffic, checked against a queue-of-outcomes model.
module tb_trdb_branch_map_decoder;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        map_valid;
  logic        map_ready;
  logic [4:0]  map_count;
  logic [30:0] map_bits;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic        out_last;
  logic [5:0]  remaining;

  trdb_branch_map_decoder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .map_valid_i (map_valid),
    .map_ready_o (map_ready),
    .map_count_i (map_count),
    .map_bits_i  (map_bits),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_taken_o (out_taken),
    .out_last_o  (out_last),
    .remaining_o (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit taken;
    bit last;
  } outcome_t;

  outcome_t q[$];
  int       nmaps;
  int       n_checks;
  int       n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("remaining", 32'(remaining), 32'(q.size()));
    chk("out_last", 32'(out_last), 32'((q.size() > 0) && q[0].last));
    if (q.size() > 0) chk("out_taken", 32'(out_taken), 32'(q[0].taken));
  endtask

  // One clock of traffic: drive, check ready, advance model and DUT, check outputs.
  task automatic step(input bit v, input logic [4:0] c, input logic [30:0] b,
                      input bit r, input bit f);
    bit exp_ready, acc, fir;
    int n;
    map_valid = v;
    map_count = c;
    map_bits  = b;
    out_ready = r;
    flush     = f;
    #1;
    exp_ready = (nmaps < 2) && !f;
    chk("map_ready", 32'(map_ready), 32'(exp_ready));
    acc = v && exp_ready;
    fir = (q.size() > 0) && r;
    @(posedge clk);
    if (f) begin
      q.delete();
      nmaps = 0;
    end else begin
      if (fir) begin
        if (q[0].last) nmaps--;
        void'(q.pop_front());
      end
      if (acc) begin
        n = (c == 0) ? 31 : int'(c);
        for (int i = 0; i < n; i++) q.push_back('{taken: !b[i], last: (i == n - 1)});
        nmaps++;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int cycles, input bit r);
    for (int i = 0; i < cycles; i++) step(1'b0, 5'd0, 31'd0, r, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    nmaps = 0;
    rst = 1'b1;
    flush = 1'b0;
    map_valid = 1'b0;
    map_count = '0;
    map_bits = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(map_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_taken", 32'(out_taken), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs();

    // Single map: taken, not-taken, taken
    step(1'b1, 5'd3, 31'b010, 1'b1, 1'b0);
    idle(4, 1'b1);
    // Full map, all not-taken
    step(1'b1, 5'd0, 31'h7FFF_FFFF, 1'b1, 1'b0);
    idle(33, 1'b1);
    // Back-to-back maps
    step(1'b1, 5'd2, 31'b01, 1'b1, 1'b0);
    step(1'b1, 5'd1, 31'b1, 1'b1, 1'b0);
    idle(4, 1'b1);
    // Last fire concurrent with accept in ONE
    step(1'b1, 5'd1, 31'b0, 1'b0, 1'b0);
    step(1'b1, 5'd4, 31'b1010, 1'b1, 1'b0);
    idle(5, 1'b1);
    // Backpressure mid-map
    step(1'b1, 5'd6, 31'b101100, 1'b1, 1'b0);
    step(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);
    idle(5, 1'b0);
    idle(7, 1'b1);
    // Flush in TWO with a map offered
    step(1'b1, 5'd5, 31'h15, 1'b0, 1'b0);
    step(1'b1, 5'd7, 31'h33, 1'b0, 1'b0);
    step(1'b1, 5'd3, 31'h7, 1'b0, 1'b1);
    step(1'b0, 5'd0, 31'd0, 1'b1, 1'b0);

    // Reset mid-map
    step(1'b1, 5'd9, 31'h1AB, 1'b1, 1'b0);
    step(1'b1, 5'd4, 31'h3, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    q.delete();
    nmaps = 0;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_remaining", 32'(remaining), 32'd0);
    chk("arst_ready", 32'(map_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle(1, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 4) != 0, 5'($urandom), 31'($urandom),
           ($urandom % 4) != 0, ($urandom % 64) == 0);
    end
    idle(70, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trdb_branch_map_decoder.md
# trdb_branch_map_decoder

Decoder-side counterpart of the encoder's branch classification. It accepts branch-map payloads recovered from format-1/2 trace packets and replays them as an ordered stream of per-branch taken/not-taken outcomes. The downstream program-flow reconstructor consumes one outcome each time it walks past a conditional branch. The block sits between the packet unpacker and the reconstructor, and double-buffers maps so that back-to-back packets do not stall the unpacker.

## Interface
Parameters:
- MAP_LEN, default 31: maximum branches per map; fixed by the packet format.
- CNT_W, default 5: width of the branch-count field.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  synchronous discard of all buffered maps, asserted on resync or format-3 packets.
- map_valid_i  in  1  a map is offered.
- map_ready_o  out  1  the block can accept a map.
- map_count_i  in  CNT_W  number of valid branches; 0 encodes MAP_LEN (full map).
- map_bits_i  in  MAP_LEN  branch outcomes; bit 0 is the oldest branch; bit value 1 means not taken, 0 means taken.
- out_valid_o  out  1  an outcome is available.
- out_ready_i  in  1  the reconstructor consumes the outcome.
- out_taken_o  out  1  outcome of the oldest unconsumed branch.
- out_last_o  out  1  the current outcome is the final branch of the active map.
- remaining_o  out  CNT_W+1  branches left across both slots, 0..2*MAP_LEN.

## Operation
- Storage has two slots: ACTIVE and PENDING. Each slot holds bits[MAP_LEN-1:0], cnt[CNT_W:0] and a valid flag.
- On map load, cnt = (map_count_i == 0) ? MAP_LEN : map_count_i.
- Slot-level state machine:
  - EMPTY: neither slot valid.
  - ONE: ACTIVE valid only.
  - TWO: both slots valid.
- Map accept happens when map_valid_i && map_ready_o.
- map_ready_o = !PENDING.valid && !flush_i. It is therefore high in EMPTY and ONE.
- Accept in EMPTY: the map loads into ACTIVE and the state moves to ONE.
- Accept in ONE:
  - Normally the map loads into PENDING and the state moves to TWO.
  - If the same cycle also consumes the last branch of ACTIVE, the map loads directly into ACTIVE and the state stays ONE.
- Outcome fire happens when out_valid_o && out_ready_i.
  - ACTIVE.bits shifts right by 1 and ACTIVE.cnt decrements.
- Last-branch fire (ACTIVE.cnt == 1):
  - From TWO: PENDING moves to ACTIVE and the state moves to ONE.
  - From ONE with no accept: the state moves to EMPTY.
- Output assignments:
  - out_valid_o = ACTIVE.valid.
  - out_taken_o = !ACTIVE.bits[0].
  - out_last_o = ACTIVE.valid && ACTIVE.cnt == 1.
- remaining_o = ACTIVE.cnt + PENDING.cnt, counting valid slots only.
- flush_i has priority over accept and fire. It clears both valid flags and both counts, drops any same-cycle map, and takes the state to EMPTY. Bits contents are don't-care after flush.
- Discarded bits of a partial map (bit index >= cnt) are never emitted.

## Timing
- Reset values:
  - map_ready_o = 1, out_valid_o = 0, out_taken_o = 0, out_last_o = 0, remaining_o = 0.
  - Internal state is EMPTY.
- Accept-to-output latency is 1 cycle: a map accepted in EMPTY at cycle N gives out_valid_o = 1 at N+1.
- Throughput is one outcome per cycle sustained. A pending map follows its predecessor with zero bubble cycles.
- All outputs are driven from registers except map_ready_o, which is combinational from PENDING.valid and flush_i.
- out_taken_o and out_last_o hold stable while out_valid_o && !out_ready_i.
- A reset asserted mid-map clears everything asynchronously. The first cycle after release behaves as EMPTY.

## Structure
- trdb_pkg defines:
  - constants BRANCH_MAP_LEN = 31 and BRANCH_CNT_W = 5;
  - the typedef branch_map_slot_t, a struct {bits, cnt, valid};
  - the enum bmap_state_e {EMPTY, ONE, TWO}.
- The block is a single module with no sub-modules. Slot update logic is written once as a function in the package and applied to both slots.

## Test plan
- **Single map:** after reset, send count=3, bits=0b010 → outcomes taken, not-taken, taken on 3 consecutive cycles. out_last_o is high on the third; then out_valid_o=0 and remaining_o=0.
- **Full map:** send count=0, bits=0x7FFF_FFFF → 31 outcomes, all not-taken. remaining_o steps 31→0 and out_last_o is high only on the 31st.
- **Back-to-back maps:** send count=2 then count=1 in consecutive cycles with out_ready_i held 1 → 3 outcomes on 3 consecutive cycles. map_ready_o=0 while both slots are full.
- **Simultaneous last fire and accept in ONE:** active map has cnt=1 and out_ready_i=1 while a new map with count=4 is offered → accepted into ACTIVE. The next cycle shows remaining_o=4 with no bubble.
- **Backpressure:** out_ready_i=0 for 5 cycles mid-map → out_taken_o, out_last_o and remaining_o stay unchanged, and no outcome is lost.
- **Flush:** flush_i in a TWO state concurrent with map_valid_i → next cycle out_valid_o=0, remaining_o=0, the offered map is dropped, and map_ready_o=1.
